// File: rtl/dpram_word_writer_pkg.sv
// Shared types for the double-width word writer.
package dpram_word_writer_pkg;

  typedef enum logic {
    StHi,
    StLo
  } state_e;

endpackage

// File: rtl/dpram_word_writer.sv
// Splits double-width input words into two single-width RAM writes, high half first,
// so that a double-width read at the word address returns the word unchanged.
module dpram_word_writer
  import dpram_word_writer_pkg::*;
#(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   addr_load_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2*DataWidth-1:0] in_data_i,
  output logic                   wren_a_o,
  output logic [AddrWidth-1:0]   address_a_o,
  output logic [DataWidth-1:0]   data_a_o,
  output logic                   busy_o
);

  state_e                 state_q;
  logic [AddrWidth-1:0]   ptr_q;
  logic [2*DataWidth-1:0] hold_data_q;
  logic                   hold_valid_q;
  logic                   accept;

  // The holding register frees up on the low-half edge, so a new word can land there.
  assign in_ready_o = !rst_i && (!hold_valid_q || (state_q == StLo));
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = hold_valid_q || (state_q == StLo);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StHi;
      ptr_q        <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      wren_a_o     <= 1'b0;
      address_a_o  <= '0;
      data_a_o     <= '0;
    end else begin
      if (accept) begin
        hold_data_q  <= in_data_i;
        hold_valid_q <= 1'b1;
      end

      unique case (state_q)
        StHi: begin
          if (hold_valid_q) begin
            wren_a_o    <= 1'b1;
            address_a_o <= ptr_q;
            data_a_o    <= hold_data_q[2*DataWidth-1 -: DataWidth];
            ptr_q       <= ptr_q + AddrWidth'(2);
            state_q     <= StLo;
          end else begin
            wren_a_o <= 1'b0;
          end
        end
        StLo: begin
          wren_a_o    <= 1'b1;
          address_a_o <= address_a_o + AddrWidth'(1);
          data_a_o    <= hold_data_q[DataWidth-1:0];
          state_q     <= StHi;
          if (!accept) begin
            hold_valid_q <= 1'b0;
          end
        end
        default: state_q <= StHi;
      endcase

      // A load wins over the increment; the write issued this edge already used the old ptr.
      if (addr_load_i) begin
        ptr_q <= addr_i;
      end
    end
  end

endmodule

// File: tb/tb_dpram_word_writer.sv
// Directed bench for dpram_word_writer with a behavioural single-write/double-read RAM.
module tb_dpram_word_writer;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned NW = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          addr_load;
  logic [AW-1:0] addr_in;
  logic          in_valid;
  logic          in_ready;
  logic [2*DW-1:0] in_data;
  logic          wren_a;
  logic [AW-1:0] address_a;
  logic [DW-1:0] data_a;
  logic          busy;

  logic [DW-1:0] mem [1<<AW];
  int n_cmp = 0;
  int n_err = 0;

  dpram_word_writer #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .addr_load_i(addr_load),
    .addr_i     (addr_in),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .wren_a_o   (wren_a),
    .address_a_o(address_a),
    .data_a_o   (data_a),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Reference RAM: single-width write port.
  always @(posedge clk) begin
    if (wren_a === 1'b1) mem[address_a] <= data_a;
  end

  function automatic logic [2*DW-1:0] rd(input logic [AW-1:0] a);
    logic [AW-1:0] a1;
    a1 = a + 1'b1;
    return {mem[a], mem[a1]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, ".wren"}, 32'(wren_a), 32'd1);
    chk({tag, ".addr"}, 32'(address_a), 32'(a));
    chk({tag, ".data"}, 32'(data_a), 32'(d));
  endtask

  task automatic load_ptr(input logic [AW-1:0] a);
    addr_load = 1'b1;
    addr_in   = a;
    step();
    addr_load = 1'b0;
  endtask

  task automatic send(input logic [2*DW-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
  endtask

  logic [2*DW-1:0] words [4];
  logic [2*DW-1:0] rwords [NW];
  int k;
  int wr_cnt;
  int cyc;
  logic acc;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst = 1'b1; addr_load = 1'b0; addr_in = '0; in_valid = 1'b0; in_data = '0;
    step();
    // Reset state
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.wren", 32'(wren_a), 32'd0);
    chk("rst.addr", 32'(address_a), 32'd0);
    chk("rst.data", 32'(data_a), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'd1);

    // Single word
    send(16'hA55A);
    chk("single.busy", 32'(busy), 32'd1);
    chk("single.ready_hold", 32'(in_ready), 32'd0);
    chk("single.wren_lat", 32'(wren_a), 32'd0);
    step();
    chk_wr("single.hi", 10'h000, 8'hA5);
    chk("single.ready_lo", 32'(in_ready), 32'd1);
    step();
    chk_wr("single.lo", 10'h001, 8'h5A);
    chk("single.busy_end", 32'(busy), 32'd0);
    step();
    chk("single.idle", 32'(wren_a), 32'd0);
    chk("single.rd", 32'(rd(10'h000)), 32'hA55A);

    // Back-to-back: accepts at cycles 0,2,4,6; writes on cycles 1..8
    load_ptr(10'h000);
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    for (int c = 0; c < 9; c++) begin
      in_valid = (c % 2 == 0) && (c < 8);
      in_data  = words[(c / 2) % 4];
      if (c < 8) chk($sformatf("b2b.ready%0d", c), 32'(in_ready), 32'((c % 2) == 0));
      step();
      if (c >= 1) begin
        chk_wr($sformatf("b2b.w%0d", c - 1), 10'(c - 1),
               ((c - 1) % 2 == 0) ? words[(c - 1) / 2][15:8] : words[(c - 1) / 2][7:0]);
      end
    end
    in_valid = 1'b0;
    step();
    chk("b2b.idle", 32'(wren_a), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b.rd%0d", i), 32'(rd(10'(2 * i))), 32'(words[i]));

    // Wrap at top of memory
    load_ptr(10'h3FF);
    send(16'h1234);
    step();
    chk_wr("wrap.hi", 10'h3FF, 8'h12);
    step();
    chk_wr("wrap.lo", 10'h000, 8'h34);
    send(16'hBEEF);
    step();
    chk_wr("wrap2.hi", 10'h001, 8'hBE);
    step();
    chk_wr("wrap2.lo", 10'h002, 8'hEF);
    step();
    chk("wrap.rd", 32'(rd(10'h3FF)), 32'h1234);
    chk("wrap2.rd", 32'(rd(10'h001)), 32'hBEEF);

    // Pointer load during the low-half edge
    load_ptr(10'h010);
    send(16'hCAFE);
    step();
    chk_wr("ldlo.hi", 10'h010, 8'hCA);
    addr_load = 1'b1;
    addr_in   = 10'h100;
    step();
    addr_load = 1'b0;
    chk_wr("ldlo.lo", 10'h011, 8'hFE);
    send(16'h0F0F);
    step();
    chk_wr("ldlo2.hi", 10'h100, 8'h0F);
    step();
    chk_wr("ldlo2.lo", 10'h101, 8'h0F);
    step();

    // Reset between the two halves
    send(16'h5678);
    step();
    chk_wr("rstmid.hi", 10'h102, 8'h56);
    rst = 1'b1;
    #1;
    chk("rstmid.wren", 32'(wren_a), 32'd0);
    chk("rstmid.addr", 32'(address_a), 32'd0);
    chk("rstmid.data", 32'(data_a), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.ready", 32'(in_ready), 32'd0);
    step();
    chk("rstmid.hold_wren", 32'(wren_a), 32'd0);
    rst = 1'b0;
    step();
    chk("rstmid.no_lo", 32'(mem[10'h103]), 32'd0);
    send(16'h9ABC);
    step();
    chk_wr("post.hi", 10'h000, 8'h9A);
    step();
    chk_wr("post.lo", 10'h001, 8'hBC);
    step();

    // Random stall against a scoreboard
    for (int i = 0; i < NW; i++) rwords[i] = 16'($urandom);
    load_ptr(10'h200);
    k = 0;
    wr_cnt = 0;
    cyc = 0;
    while (k < NW && cyc < 5000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = in_valid ? rwords[k] : 16'($urandom);
      acc = in_valid && in_ready;
      step();
      if (wren_a) wr_cnt++;
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stall.all_accepted", 32'(k), 32'(NW));
    for (int i = 0; i < 4; i++) begin
      step();
      if (wren_a) wr_cnt++;
    end
    chk("stall.wr_count", 32'(wr_cnt), 32'(2 * NW));
    chk("stall.busy_end", 32'(busy), 32'd0);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("stall.rd%0d", i), 32'(rd(10'(10'h200 + 2 * i))), 32'(rwords[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
